conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_line_buffer.sv | 35 +++
 rtl/conv_window_gen.sv | 159 +++++++++++++++
 tb/tb_conv_window_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the sliding-window generator.
// Holds the tap index, the legal-kernel check and the coordinate widths.
package conv_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic int tap_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  function automatic bit kernel_legal(input int k);
    return (k == 1) || (k == 3) || (k == 5) || (k == 7);
  endfunction

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: the output is the value shifted in DEPTH
// accepted pixels earlier, i.e. the pixel directly above.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Contents are overwritten before they can reach a valid window.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// KERNEL x KERNEL sliding-window generator over a raster pixel stream.
// Define CONV_WIN_POS_EN to add the win_x/win_y window coordinate outputs.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int CL_IN  = 8,
  parameter int KERNEL = 3,
  parameter int N      = 2,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CL_IN*N-1:0]               pix_in,
  input  logic                             pix_valid,
  input  logic                             sof,
  output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
  output logic                             en_out,
  output logic                             frame_done,
  output logic                             sof_err
`ifdef CONV_WIN_POS_EN
  ,
  output logic [coord_w(IMG_W)-1:0]        win_x,
  output logic [coord_w(IMG_H)-1:0]        win_y
`endif
);

  localparam int KK = KERNEL * KERNEL;
  localparam int PW = CL_IN * N;
  localparam int WW = PW * KK;
  localparam int XW = coord_w(IMG_W);
  localparam int YW = coord_w(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  if (!kernel_legal(KERNEL) || IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_cfg
    $error("conv_window_gen: illegal KERNEL/IMG_W/IMG_H");
  end

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, cur_x;
  logic [YW-1:0]   y_q, y_d, cur_y;
  logic            en_q, en_d;
  logic            fd_q, fd_d;
  logic            serr_q, serr_d;
  logic [WW-1:0]   win_q, win_d;
  logic            restart, accept, win_ok, last;
  logic [PW-1:0]   lb_io [KERNEL];

  // lb_io[j] is the pixel j rows above the incoming one.
  assign lb_io[0] = pix_in;

  for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
    conv_line_buffer #(
      .DEPTH(IMG_W),
      .DW   (PW)
    ) u_lb (
      .clk (clk),
      .en  (accept),
      .din (lb_io[j]),
      .dout(lb_io[j+1])
    );
  end

  always_comb begin
    restart = pix_valid & sof;
    accept  = pix_valid & (restart | (state_q == RUN));
    cur_x   = restart ? '0 : x_q;
    cur_y   = restart ? '0 : y_q;
    win_ok  = (int'(cur_x) >= KERNEL - 1) && (int'(cur_y) >= KERNEL - 1);
    last    = (cur_x == X_LAST) && (cur_y == Y_LAST);
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    en_d    = 1'b0;
    fd_d    = 1'b0;
    serr_d  = 1'b0;
    win_d   = win_q;
    if (accept) begin
      serr_d  = restart && (state_q == RUN);
      en_d    = win_ok;
      fd_d    = last;
      state_d = last ? IDLE : RUN;
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
      for (int ch = 0; ch < CL_IN; ch++) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL; c++) begin
            if (c < KERNEL - 1) begin
              win_d[(ch*KK + tap_idx(r, c, KERNEL))*N +: N] =
                win_q[(ch*KK + tap_idx(r, c + 1, KERNEL))*N +: N];
            end else begin
              win_d[(ch*KK + tap_idx(r, c, KERNEL))*N +: N] =
                lb_io[KERNEL-1-r][ch*N +: N];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
      serr_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      serr_q  <= serr_d;
      win_q   <= win_d;
    end
  end

  assign data2conv  = win_q;
  assign en_out     = en_q;
  assign frame_done = fd_q;
  assign sof_err    = serr_q;

`ifdef CONV_WIN_POS_EN
  logic [XW-1:0] wx_q, wx_d;
  logic [YW-1:0] wy_q, wy_d;

  always_comb begin
    wx_d = wx_q;
    wy_d = wy_q;
    if (accept && win_ok) begin
      wx_d = cur_x;
      wy_d = cur_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wx_q <= '0;
      wy_q <= '0;
    end else begin
      wx_q <= wx_d;
      wy_q <= wy_d;
    end
  end

  assign win_x = wx_q;
  assign win_y = wy_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a 3x3 4x4 instance and a 1x1 2x2 one.
// Window coordinates are also checked when CONV_WIN_POS_EN is defined.
module tb_conv_window_gen;

  typedef struct {
    logic [63:0] d;
    bit          fd;
    int          due;
    int          wx;
    int          wy;
  } exp_t;

  logic        clk;
  logic        rst;
  int          edge_n;
  int          n_checks;
  int          n_fail;

  logic [3:0]  a_pix;
  logic        a_valid, a_sof;
  logic [35:0] a_data;
  logic        a_en, a_fd, a_serr;

  logic [3:0]  b_pix;
  logic        b_valid, b_sof;
  logic [3:0]  b_data;
  logic        b_en, b_fd, b_serr;

`ifdef CONV_WIN_POS_EN
  logic [1:0]  a_wx, a_wy;
  logic [0:0]  b_wx, b_wy;
`endif

  exp_t        qa[$];
  exp_t        qb[$];

  // Hand-computed windows for pixels 10, 11, 14, 15 (nibble t0 lowest).
  logic [35:0] win_a [4] = '{36'hA98654210, 36'hBA9765321,
                             36'hEDCA98654, 36'hFEDBA9765};
  int          wx_a  [4] = '{2, 3, 2, 3};
  int          wy_a  [4] = '{2, 2, 3, 3};
  logic [3:0]  pix_b [4] = '{4'h9, 4'h3, 4'hC, 4'h6};

  conv_window_gen #(
    .CL_IN(1), .KERNEL(3), .N(4), .IMG_W(4), .IMG_H(4)
  ) u_a (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (a_pix),
    .pix_valid (a_valid),
    .sof       (a_sof),
    .data2conv (a_data),
    .en_out    (a_en),
    .frame_done(a_fd),
    .sof_err   (a_serr)
`ifdef CONV_WIN_POS_EN
    ,
    .win_x     (a_wx),
    .win_y     (a_wy)
`endif
  );

  conv_window_gen #(
    .CL_IN(2), .KERNEL(1), .N(2), .IMG_W(2), .IMG_H(2)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (b_pix),
    .pix_valid (b_valid),
    .sof       (b_sof),
    .data2conv (b_data),
    .en_out    (b_en),
    .frame_done(b_fd),
    .sof_err   (b_serr)
`ifdef CONV_WIN_POS_EN
    ,
    .win_x     (b_wx),
    .win_y     (b_wy)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_en) begin
      chk("a_en_expected", 64'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_latency", edge_n, e.due);
        chk("a_data", a_data, e.d);
        chk("a_frame_done", a_fd, e.fd);
`ifdef CONV_WIN_POS_EN
        chk("a_win_x", a_wx, e.wx);
        chk("a_win_y", a_wy, e.wy);
`endif
      end
    end else begin
      chk("a_fd_without_en", a_fd, 0);
      if (qa.size() != 0 && edge_n >= qa[0].due) begin
        chk("a_en_missing", a_en, 1);
        void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_en) begin
      chk("b_en_expected", 64'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_latency", edge_n, e.due);
        chk("b_data", b_data, e.d);
        chk("b_frame_done", b_fd, e.fd);
`ifdef CONV_WIN_POS_EN
        chk("b_win_x", b_wx, e.wx);
        chk("b_win_y", b_wy, e.wy);
`endif
      end
    end else begin
      chk("b_fd_without_en", b_fd, 0);
      if (qb.size() != 0 && edge_n >= qb[0].due) begin
        chk("b_en_missing", b_en, 1);
        void'(qb.pop_front());
      end
    end
  end

  task automatic px(input logic [3:0] v, input bit s, input int wi);
    a_pix   = v;
    a_valid = 1'b1;
    a_sof   = s;
    if (wi >= 0) begin
      qa.push_back('{d: 64'(win_a[wi]), fd: (wi == 3), due: edge_n + 1,
                     wx: wx_a[wi], wy: wy_a[wi]});
    end
    @(negedge clk);
  endtask

  task automatic gap();
    logic [35:0] snap;
    snap    = a_data;
    a_valid = 1'b0;
    a_sof   = 1'b0;
    @(negedge clk);
    chk("a_hold_in_gap", a_data, snap);
  endtask

  task automatic drain();
    a_valid = 1'b0;
    a_sof   = 1'b0;
    b_valid = 1'b0;
    b_sof   = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_all_windows_seen", qa.size(), 0);
    chk("b_all_windows_seen", qb.size(), 0);
  endtask

  task automatic frame(input bit gaps, input bit serr);
    int wi;
    for (int p = 0; p < 16; p++) begin
      wi = (p == 10) ? 0 : (p == 11) ? 1 : (p == 14) ? 2 : (p == 15) ? 3 : -1;
      px(4'(p), p == 0, wi);
      if (p == 0) chk("a_sof_err", a_serr, serr);
      if (p == 1) chk("a_sof_err_pulse_end", a_serr, 0);
      if (gaps) gap();
    end
    drain();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en_out"}, a_en, 0);
    chk({tag, "_frame_done"}, a_fd, 0);
    chk({tag, "_sof_err"}, a_serr, 0);
    chk({tag, "_data2conv"}, a_data, 0);
    chk({tag, "_b_data2conv"}, b_data, 0);
`ifdef CONV_WIN_POS_EN
    chk({tag, "_win_x"}, a_wx, 0);
    chk({tag, "_win_y"}, a_wy, 0);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    a_pix    = '0;
    a_valid  = 1'b0;
    a_sof    = 1'b0;
    b_pix    = '0;
    b_valid  = 1'b0;
    b_sof    = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Pixels without sof while idle must be ignored.
    repeat (3) px(4'd5, 1'b0, -1);
    a_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_change", a_data, 0);

    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);

    // Restart mid-frame at the seventh pixel.
    for (int p = 0; p < 6; p++) px(4'(p + 3), p == 0, -1);
    frame(1'b0, 1'b1);

    // Reset after pixel 9, then stray pixels, then a clean frame.
    for (int p = 0; p < 10; p++) px(4'(p), p == 0, -1);
    rst     = 1'b1;
    a_valid = 1'b0;
    a_sof   = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    for (int p = 10; p < 16; p++) px(4'(p), 1'b0, -1);
    a_valid = 1'b0;
    @(negedge clk);
    chk("after_reset_ignored", a_data, 0);
    frame(1'b0, 1'b0);

    // 1x1 kernel: every pixel is a window equal to itself.
    for (int i = 0; i < 4; i++) begin
      b_pix   = pix_b[i];
      b_valid = 1'b1;
      b_sof   = (i == 0);
      qb.push_back('{d: 64'(pix_b[i]), fd: (i == 3), due: edge_n + 1,
                     wx: i % 2, wy: i / 2});
      @(negedge clk);
      chk("b_sof_err", b_serr, 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
